// File: rtl/div_seq_ctrl.sv
// Radix-2 shift-subtract divider for RV32M DIV/DIVU/REM/REMU; stalls EX while busy, pulses done for one cycle.
// Latency XLEN+2 edges (2 for div-by-zero/overflow, and for |a|<|b| when DIV_EARLY_OUT_EN is defined).
module div_seq_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [1:0]      div_op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic [4:0]      rd_addr_in,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_addr_out
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_ITER  = 3'd2;
   localparam logic [2:0] S_FIX   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]      state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] dvd;
   logic [XLEN-1:0] dvs;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic            sel_rem;
   logic [4:0]      rd_q;
   logic            neg_q;
   logic            neg_r;
   logic            ovf;

   logic            sign1;
   logic            sign2;
   logic [XLEN-1:0] mag1;
   logic [XLEN-1:0] mag2;
   logic [XLEN:0]   rem_sh;
   logic            q_bit;
   logic [XLEN-1:0] rem_nx;
   logic [XLEN-1:0] fix_q;
   logic [XLEN-1:0] fix_r;
   logic            early;

   assign sign1 = ~div_op[0] & src1[XLEN-1];
   assign sign2 = ~div_op[0] & src2[XLEN-1];
   assign mag1  = sign1 ? (~src1 + 1'b1) : src1;
   assign mag2  = sign2 ? (~src2 + 1'b1) : src2;

   // One restoring step: compare at XLEN+1 bits so the shifted-in bit never overflows.
   assign rem_sh = {rem, dvd[XLEN-1]};
   assign q_bit  = (rem_sh >= {1'b0, dvs});
   assign rem_nx = q_bit ? (rem_sh[XLEN-1:0] - dvs) : rem_sh[XLEN-1:0];

   assign fix_q = neg_q ? (~quo + 1'b1) : quo;
   assign fix_r = neg_r ? (~rem + 1'b1) : rem;

`ifdef DIV_EARLY_OUT_EN
   assign early = (dvd < dvs);
`else
   assign early = 1'b0;
`endif

   assign stall = ((state == S_IDLE) || (state == S_DONE)) ? start
                : ((state == S_CHECK) || (state == S_ITER) || (state == S_FIX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         dvd         <= '0;
         dvs         <= '0;
         quo         <= '0;
         rem         <= '0;
         sel_rem     <= 1'b0;
         rd_q        <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         ovf         <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         rd_addr_out <= '0;
      end else if (flush) begin
         state <= S_IDLE;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  dvd     <= mag1;
                  dvs     <= mag2;
                  sel_rem <= div_op[1];
                  rd_q    <= rd_addr_in;
                  neg_q   <= sign1 ^ sign2;
                  neg_r   <= sign1;
                  ovf     <= ~div_op[0] && (src1 == INT_MIN) && (src2 == '1);
                  cnt     <= '0;
                  state   <= S_CHECK;
               end else begin
                  state <= S_IDLE;
               end
            end
            // Special cases preload final magnitudes and leave through FIX,
            // so every result is formatted by the same sign/select logic.
            S_CHECK: begin
               state <= S_FIX;
               if (dvs == '0) begin
                  quo   <= '1;
                  rem   <= dvd;
                  neg_q <= 1'b0;
               end else if (ovf) begin
                  quo   <= INT_MIN;
                  rem   <= '0;
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
               end else if (early) begin
                  quo   <= '0;
                  rem   <= dvd;
                  neg_q <= 1'b0;
               end else begin
                  quo   <= '0;
                  rem   <= '0;
                  cnt   <= '0;
                  state <= S_ITER;
               end
            end
            S_ITER: begin
               rem <= rem_nx;
               dvd <= {dvd[XLEN-2:0], 1'b0};
               quo <= {quo[XLEN-2:0], q_bit};
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST)
                  state <= S_FIX;
            end
            S_FIX: begin
               result      <= sel_rem ? fix_r : fix_q;
               rd_addr_out <= rd_q;
               done        <= 1'b1;
               state       <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: randomized RV32M divides against an arithmetic reference model.
module tb_div_seq_ctrl;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            flush = 1'b0;
   logic [1:0]      div_op = '0;
   logic [XLEN-1:0] src1 = '0;
   logic [XLEN-1:0] src2 = '0;
   logic [4:0]      rd_addr_in = '0;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_addr_out;

   div_seq_ctrl #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .div_op(div_op),
      .src1(src1), .src2(src2), .rd_addr_in(rd_addr_in), .stall(stall),
      .done(done), .result(result), .rd_addr_out(rd_addr_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [XLEN-1:0] res;
      logic [4:0]      rd;
      int              due;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: RV32M semantics straight from the operator definitions.
   function automatic void model(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 output logic [XLEN-1:0] res, output int lat);
      logic [XLEN-1:0] q, r, ma, mb;
      bit sgn, special;
      sgn = !op[0];
      if (b == 0) begin
         q = '1; r = a; special = 1;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 0; special = 1;
      end else if (sgn) begin
         q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); special = 0;
      end else begin
         q = a / b; r = a % b; special = 0;
      end
      ma = (sgn && a[XLEN-1]) ? -a : a;
      mb = (sgn && b[XLEN-1]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) special = 1;
`endif
      lat = special ? 2 : XLEN + 2;
      res = op[1] ? r : q;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done: result %0h with nothing outstanding (cycle %0d)", result, cyc);
         end else begin
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("rd_addr_out", rd_addr_out, e.rd);
            chk("done_cycle", cyc, e.due);
         end
      end
   end

   // Issue one op from a negedge; returns at the negedge where done is high.
   task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [4:0] rd);
      exp_t e;
      logic [XLEN-1:0] r;
      int lat, n;
      model(op, a, b, r, lat);
      e.res = r; e.rd = rd; e.due = cyc + 1 + lat;
      sb.push_back(e);
      div_op = op; src1 = a; src2 = b; rd_addr_in = rd; start = 1'b1;
      #1 chk("stall_on_start", stall, 1);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 60) begin
         chk("stall_busy", stall, 1);
         @(negedge clk);
         n++;
      end
      if (!done) begin
         tests++; fails++;
         $display("FAIL done_timeout: no done within 60 cycles for op %0d %0h/%0h", op, a, b);
         sb.delete();
      end else begin
         chk("stall_in_done", stall, 0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic expect_quiet(input string name, input int n);
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done || stall) seen++;
      end
      chk(name, seen, 0);
   endtask

   initial begin
      logic [XLEN-1:0] old_res, a, b;
      logic [1:0] op;
      int cls;

      idle(3);
      chk("reset_done", done, 0);
      chk("reset_result", result, 0);
      chk("reset_rd", rd_addr_out, 0);
      chk("reset_stall", stall, 0);
      rst = 1'b0;
      idle(2);

      run_op(2'b01, 32'd100, 32'd7, 5'd5);              idle(2);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6);        idle(1);
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7);        idle(1);
      run_op(2'b00, 32'd5, 32'd0, 5'd8);                idle(1);
      run_op(2'b11, 32'd5, 32'd0, 5'd9);                idle(1);
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10); idle(1);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11); idle(1);

      // Back-to-back: second start issued in the DONE cycle.
      run_op(2'b01, 32'd3, 32'd9, 5'd12);
      run_op(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd13);
      run_op(2'b11, 32'd1000, 32'd33, 5'd14);
      idle(2);

      // Flush in ITER cycle 10.
      old_res = result;
      div_op = 2'b01; src1 = 32'd1_000_000; src2 = 32'd3; rd_addr_in = 5'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      idle(11);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_stall", stall, 0);
      chk("flush_done", done, 0);
      expect_quiet("flush_quiet", 40);
      chk("flush_result_kept", result, old_res);

      // Start together with flush is dropped.
      div_op = 2'b01; src1 = 32'd50; src2 = 32'd0; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      expect_quiet("flush_drops_start", 10);

      // Asynchronous reset mid-operation.
      div_op = 2'b00; src1 = 32'd77777; src2 = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      idle(5);
      rst = 1'b1;
      #1;
      chk("rst_mid_result", result, 0);
      chk("rst_mid_stall", stall, 0);
      @(negedge clk);
      rst = 1'b0;
      expect_quiet("rst_mid_quiet", 40);

      for (int i = 0; i < 60; i++) begin
         op  = 2'($urandom_range(0, 3));
         cls = $urandom_range(0, 4);
         a = $urandom; b = $urandom;
         case (cls)
            1: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
            2: b = 0;
            3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            4: begin a = $urandom_range(0, 1000); b = b | 32'h0010_0000; end
            default: ;
         endcase
         if (cls == 1 && $urandom_range(0, 1) == 1) a = -a;
         run_op(op, a, b, 5'($urandom));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(3);
      chk("scoreboard_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

endmodule
